// File: rtl/btn_step_pulse.sv
`default_nettype none
// ============================================================================
// Module      : btn_step_pulse
// Description : Turns a raw mechanical push-button level into a clean,
//               single-cycle step enable. The raw level is brought into the
//               clock domain through a two-flop synchronizer and is then
//               debounced symmetrically: a press or a release is accepted
//               only after the synchronized level has stayed put for
//               DEBOUNCE_CYCLES cycles. An optional auto-repeat re-fires the
//               step pulse every REPEAT_CYCLES cycles while the button is
//               held (REPEAT_CYCLES = 0 disables repeat).
//
// Ports       : clk        system clock, rising edge
//               rst        synchronous reset, active-high
//               btn_in     raw asynchronous button level, 1 = pressed
//               btn_step   one-cycle pulse per accepted press / repeat
//               btn_level  debounced button level
//
// Revision    : 1.0  initial release
// ============================================================================
module btn_step_pulse #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_step,
    output logic btn_level
);

    // Counter width covers the larger of the two intervals, plus one bit of
    // headroom so the terminal values are always representable.
    localparam int c_CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ?
                               DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W     = $clog2(c_CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With repeat disabled the terminal value is irrelevant; clamp it to zero
    // so no negative constant is ever formed.
    localparam logic [CNT_W-1:0] c_RPT_LAST =
        CNT_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam logic             c_RPT_EN   = (REPEAT_CYCLES != 0);

    localparam logic [1:0] c_ST_IDLE        = 2'd0;
    localparam logic [1:0] c_ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] c_ST_HELD        = 2'd2;
    localparam logic [1:0] c_ST_RELEASE_CHK = 2'd3;

    logic             r_s1;
    logic             r_sync;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic             r_step;
    logic             r_level;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_rpt_cnt_nxt;
    logic             w_step_nxt;
    logic             w_level_nxt;

    // ------------------------------------------------------------------------
    // Synchronizer and state/output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_sync    <= 1'b0;
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_rpt_cnt <= '0;
            r_step    <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            r_s1      <= btn_in;
            r_sync    <= r_s1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_step    <= w_step_nxt;
            r_level   <= w_level_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Only the synchronized level is used
    // here, so nothing combinational reaches the outputs from btn_in.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rpt_cnt_nxt = r_rpt_cnt;
        w_step_nxt    = 1'b0;           // pulse is re-armed every cycle
        w_level_nxt   = r_level;

        case (r_state)
            c_ST_IDLE: begin
                if (r_sync) begin
                    w_state_nxt = c_ST_PRESS_CHK;
                    w_cnt_nxt   = '0;
                end
            end

            c_ST_PRESS_CHK: begin
                if (!r_sync) begin
                    // Bounce: drop back without a pulse.
                    w_state_nxt = c_ST_IDLE;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_nxt   = c_ST_HELD;
                    w_step_nxt    = 1'b1;
                    w_level_nxt   = 1'b1;
                    w_rpt_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            c_ST_HELD: begin
                if (!r_sync) begin
                    w_state_nxt = c_ST_RELEASE_CHK;
                    w_cnt_nxt   = '0;
                end else if (c_RPT_EN) begin
                    if (r_rpt_cnt == c_RPT_LAST) begin
                        w_step_nxt    = 1'b1;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + CNT_W'(1);
                    end
                end
            end

            c_ST_RELEASE_CHK: begin
                if (r_sync) begin
                    // Release bounce: still held, restart the repeat interval.
                    w_state_nxt   = c_ST_HELD;
                    w_rpt_cnt_nxt = '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt   = c_ST_IDLE;
                w_cnt_nxt     = '0;
                w_rpt_cnt_nxt = '0;
                w_level_nxt   = 1'b0;
            end
        endcase
    end

    assign btn_step  = r_step;
    assign btn_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_btn_step_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_step_pulse
// Description : Self-checking bench for btn_step_pulse. Two instances with
//               DEBOUNCE_CYCLES = 4 run side by side on the same button
//               input, one without auto-repeat and one with REPEAT_CYCLES = 6.
//               A run-length reference model predicts both every cycle;
//               directed steps add latency, pulse-count and downstream
//               2-bit step-counter checks, followed by random bouncing.
//
// Ports       : none
//
// Revision    : 1.0  initial release
// ============================================================================
module tb_btn_step_pulse;

    localparam int D = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic btn_in = 1'b0;
    logic step0, level0, step6, level6;

    btn_step_pulse #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (0)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_step  (step0),
        .btn_level (level0)
    );

    btn_step_pulse #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (6)
    ) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_step  (step6),
        .btn_level (level6)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: synchronizer delay line plus, per instance, the
    // accepted level and the length of the current run of opposite samples.
    logic m_s1   = 1'b0;
    logic m_sync = 1'b0;
    int   rcfg[2]       = '{0, 6};
    int   lvl[2]        = '{0, 0};
    int   run[2]        = '{0, 0};
    int   since[2]      = '{0, 0};
    int   rel[2]        = '{0, 0};
    int   exp_step[2]   = '{0, 0};

    int   pulses[2]     = '{0, 0};
    int   last_pulse[2] = '{0, 0};
    int   fall_cyc[2]   = '{0, 0};
    logic prev_step[2]  = '{1'b0, 1'b0};
    logic prev_lvl[2]   = '{1'b0, 1'b0};
    logic [1:0] q = 2'd0;   // downstream 2-bit state stage fed by step0

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic b);
        logic s;
        if (rst) begin
            m_s1   = 1'b0;
            m_sync = 1'b0;
            for (int i = 0; i < 2; i++) begin
                lvl[i] = 0; run[i] = 0; since[i] = 0; rel[i] = 0; exp_step[i] = 0;
            end
        end else begin
            s = m_sync;
            for (int i = 0; i < 2; i++) begin
                exp_step[i] = 0;
                if (lvl[i] == 0) begin
                    run[i] = s ? run[i] + 1 : 0;
                    // Press accepted once D+1 consecutive high samples seen.
                    if (run[i] == D + 1) begin
                        lvl[i] = 1; run[i] = 0; since[i] = 0; rel[i] = 0;
                        exp_step[i] = 1;
                    end
                end else if (!s) begin
                    run[i]++;
                    rel[i] = 1;
                    if (run[i] == D + 1) begin
                        lvl[i] = 0; run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                    if (rel[i] != 0) begin
                        rel[i] = 0; since[i] = 0;   // held again after a glitch
                    end else begin
                        since[i]++;
                        if (rcfg[i] != 0 && (since[i] % rcfg[i]) == 0)
                            exp_step[i] = 1;
                    end
                end
            end
            m_sync = m_s1;
            m_s1   = b;
        end
    endtask

    task automatic tick(input logic b);
        logic st[2];
        logic lv[2];
        btn_in = b;
        @(posedge clk);
        cyc++;
        model_edge(b);
        #1;
        st[0] = step0; st[1] = step6;
        lv[0] = level0; lv[1] = level6;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("step[%0d]@%0d", i, cyc), 32'(st[i]), 32'(exp_step[i]));
            chk($sformatf("level[%0d]@%0d", i, cyc), 32'(lv[i]), 32'(lvl[i]));
            chk($sformatf("nodouble[%0d]@%0d", i, cyc), 32'(prev_step[i] & st[i]), 32'd0);
            if (st[i] === 1'b1) begin
                pulses[i]++;
                last_pulse[i] = cyc;
            end
            if (prev_lvl[i] === 1'b1 && lv[i] === 1'b0) fall_cyc[i] = cyc;
            prev_step[i] = st[i];
            prev_lvl[i]  = lv[i];
        end
        if (rst) q = 2'd0;
        else if (st[0] === 1'b1) q = q + 2'd1;
    endtask

    initial begin
        int p0, p1, k, m, b, len;

        // 1. Reset with button released.
        rst = 1'b1;
        repeat (3) tick(1'b0);
        chk("t1_step0", 32'(step0), 32'd0);
        chk("t1_level0", 32'(level0), 32'd0);
        chk("t1_step6", 32'(step6), 32'd0);
        chk("t1_level6", 32'(level6), 32'd0);
        rst = 1'b0;
        repeat (3) tick(1'b0);

        // 2. Clean press held 20 cycles, then clean release.
        p0 = pulses[0]; p1 = pulses[1]; k = cyc + 1;
        repeat (20) tick(1'b1);
        chk("t2_pulses", 32'(pulses[0] - p0), 32'd1);
        chk("t2_latency", 32'(last_pulse[0]), 32'(k + 6));
        chk("t2_level", 32'(level0), 32'd1);
        chk("t2_rpt6_pulses", 32'(pulses[1] - p1), 32'd3);
        m = cyc + 1;
        repeat (10) tick(1'b0);
        chk("t2_fall", 32'(fall_cyc[0]), 32'(m + 6));
        chk("t2_level_low", 32'(level0), 32'd0);

        // 3. Short bounces never qualify.
        p0 = pulses[0]; p1 = pulses[1];
        repeat (5) begin
            tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
        end
        repeat (4) tick(1'b0);
        chk("t3_pulses0", 32'(pulses[0] - p0), 32'd0);
        chk("t3_pulses6", 32'(pulses[1] - p1), 32'd0);
        chk("t3_level0", 32'(level0), 32'd0);
        chk("t3_level6", 32'(level6), 32'd0);

        // 4. Accepted press, release with a one-cycle re-high glitch.
        repeat (8) tick(1'b1);
        p0 = pulses[0];
        tick(1'b0);
        tick(1'b1);
        m = cyc + 1;
        repeat (12) tick(1'b0);
        chk("t4_no_extra", 32'(pulses[0] - p0), 32'd0);
        chk("t4_fall", 32'(fall_cyc[0]), 32'(m + 6));

        // 5. Auto-repeat every 6 cycles over a 30-cycle hold.
        p1 = pulses[1]; k = cyc + 1;
        repeat (36) tick(1'b1);
        chk("t5_rpt_count", 32'(pulses[1] - p1), 32'd5);
        chk("t5_last_rpt", 32'(last_pulse[1]), 32'(k + 6 + 24));
        repeat (12) tick(1'b0);

        // 6. Reset during the press check, then step counter wrap.
        repeat (3) tick(1'b1);
        rst = 1'b1;
        tick(1'b1);
        chk("t6_rst_step", 32'(step0), 32'd0);
        chk("t6_rst_level", 32'(level0), 32'd0);
        chk("t6_rst_q", 32'(q), 32'd0);
        rst = 1'b0;
        p0 = pulses[0]; k = cyc + 1;
        repeat (8) tick(1'b1);
        chk("t6_pulses", 32'(pulses[0] - p0), 32'd1);
        chk("t6_latency", 32'(last_pulse[0]), 32'(k + 6));
        repeat (10) tick(1'b0);
        chk("t6_q1", 32'(q), 32'd1);
        for (int n = 2; n <= 5; n++) begin
            repeat (8) tick(1'b1);
            repeat (10) tick(1'b0);
            chk($sformatf("t6_q%0d", n), 32'(q), 32'(n % 4));
        end

        // 7. Random bouncing with occasional resets.
        repeat (60) begin
            b   = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                tick(b[0]);
                rst = 1'b0;
            end
            repeat (len) tick(b[0]);
        end
        repeat (12) tick(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
